gates: RTL and testbench

GATES -- requirements
Module: gates

---
 rtl/gates_pkg.sv | 27 ++
 rtl/gates_debounce.sv | 31 +++
 rtl/gates.sv | 62 ++++++
 tb/tb_gates.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gates_pkg.sv
// Shared constants for the gates block: LED bit positions, reset code and the gate encoder.
package gates_pkg;

  localparam int LED_W    = 6;
  localparam int LED_AND  = 0;
  localparam int LED_OR   = 1;
  localparam int LED_NAND = 2;
  localparam int LED_NOR  = 3;
  localparam int LED_XOR  = 4;
  localparam int LED_XNOR = 5;

  // Gate results for a=0, b=0.
  localparam logic [LED_W-1:0] LED_RST = 6'b101100;

  function automatic logic [LED_W-1:0] gate_code(input logic x, input logic y);
    logic [LED_W-1:0] c;
    c           = '0;
    c[LED_AND]  = x & y;
    c[LED_OR]   = x | y;
    c[LED_NAND] = ~(x & y);
    c[LED_NOR]  = ~(x | y);
    c[LED_XOR]  = x ^ y;
    c[LED_XNOR] = ~(x ^ y);
    return c;
  endfunction

endpackage

// File: rtl/gates_debounce.sv
// Debounce filter: dout follows din only after din has differed for DEBOUNCE_CYCLES cycles.
module gates_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Accepting when the counter would reach DEBOUNCE_CYCLES keeps it below the wrap point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gates.sv
// Two switch inputs, synchronized and optionally debounced, drive six registered gate LEDs.
// Define GATES_DEBOUNCE_EN to include the debounce filters; otherwise the synchronized inputs are used directly.
module gates
  import gates_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic [LED_W-1:0] led
);

  logic a_s1, a_s, b_s1, b_s;
  logic a_f, b_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s  <= 1'b0;
      b_s1 <= 1'b0;
      b_s  <= 1'b0;
    end else begin
      a_s1 <= a;
      a_s  <= a_s1;
      b_s1 <= b;
      b_s  <= b_s1;
    end
  end

`ifdef GATES_DEBOUNCE_EN
  gates_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (a_s),
    .dout (a_f)
  );

  gates_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (b_s),
    .dout (b_f)
  );
`else
  // Filter absent: the debounce length has no effect on this build.
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign a_f = a_s;
  assign b_f = b_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_RST;
    end else begin
      led <= gate_code(a_f, b_f);
    end
  end

endmodule

// File: tb/tb_gates.sv
// Directed bench for gates: reset, truth table with latency, glitch handling, mid-count reset.
module tb_gates;

`ifdef GATES_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  localparam logic [5:0] C00 = 6'b101100;
  localparam logic [5:0] C01 = 6'b010110;
  localparam logic [5:0] C10 = 6'b010110;
  localparam logic [5:0] C11 = 6'b100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b;
  logic [5:0] led;

  int n_cmp = 0;
  int n_err = 0;

  gates #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .led  (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    n_cmp++;
    assert (led === exp)
    else begin
      n_err++;
      $error("FAIL %s: led=%b expected=%b", tag, led, exp);
    end
  endtask

  // Apply a new input pair, then check led every cycle for 50 cycles.
  task automatic step(input logic na, input logic nb, input logic [5:0] old_c,
                      input logic [5:0] new_c, input string tag);
    a = na;
    b = nb;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk(tag, (k < LAT) ? old_c : new_c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 1'b1;
    b     = 1'b1;

    for (int k = 0; k < 5; k++) begin
      tick();
      chk("reset_hold", C00);
    end
    a = 1'b0;
    b = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("after_release", C00);
    end

    step(1'b0, 1'b1, C00, C01, "tt_01");
    step(1'b1, 1'b0, C01, C10, "tt_10");
    step(1'b1, 1'b1, C10, C11, "tt_11");
    step(1'b0, 1'b0, C11, C00, "tt_00");

`ifdef GATES_DEBOUNCE_EN
    a = 1'b1;
    tick();
    chk("glitch", C00);
    tick();
    chk("glitch", C00);
    tick();
    chk("glitch", C00);
    a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("glitch", C00);
    end
`else
    a = 1'b1;
    tick();
    a = 1'b0;
    chk("pulse_pass", C00);
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk("pulse_pass", (k == 3) ? C10 : C00);
    end
`endif

    a = 1'b1;
    tick();
    chk("midcnt_pre", C00);
    tick();
    chk("midcnt_pre", C00);
    rst_n = 1'b0;
    #1;
    chk("midcnt_rst", C00);
    tick();
    chk("midcnt_rst", C00);
    tick();
    chk("midcnt_rst", C00);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("midcnt_post", (k < LAT) ? C00 : C10);
    end

    step(1'b0, 1'b0, C10, C00, "back_00");
    step(1'b1, 1'b1, C00, C11, "step_11");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
